// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port data memory.
// The memory has a synchronous write and a combinational read. When both
// requesters ask at once, the one not served last wins. A requester may lock
// ownership across accesses. A lock held for LOCK_MAX cycles is forcibly released.
module mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int LOCK_MAX = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  // requester 0 (CPU load/store)
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  input  logic          r0_lock,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  // requester 1 (loader/DMA)
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  input  logic          r1_lock,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  // status
  output logic          lock_timeout,
  // memory side
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat_in,
  output logic          mem_wr_en,
  input  logic [DW-1:0] mem_dat_out
);

  localparam int CW = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_srv_q, last_srv_d;   // index of the requester served last
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;   // cycles spent in the current lock
  logic          r0_rvalid_q, r0_rvalid_d;
  logic          r1_rvalid_q, r1_rvalid_d;
  logic [DW-1:0] r0_rdata_q, r0_rdata_d;
  logic [DW-1:0] r1_rdata_q, r1_rdata_d;

  // Grant decision and memory port mux; everything is forced idle while in reset.
  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    r0_gnt       = 1'b0;
    r1_gnt       = 1'b0;
    lock_timeout = 1'b0;
    mem_addr     = '0;
    mem_dat_in   = '0;
    mem_wr_en    = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (r0_req && r1_req) begin
            r0_gnt = last_srv_q;
            r1_gnt = !last_srv_q;
          end else begin
            r0_gnt = r0_req;
            r1_gnt = r1_req;
          end
        end
        LOCK0: begin
          if (lock_cnt_q == LOCK_LAST) lock_timeout = 1'b1;
          else                         r0_gnt       = r0_req;
        end
        LOCK1: begin
          if (lock_cnt_q == LOCK_LAST) lock_timeout = 1'b1;
          else                         r1_gnt       = r1_req;
        end
        default: ;
      endcase
    end
    if (r0_gnt) begin
      mem_addr   = r0_addr;
      mem_dat_in = r0_wdata;
      mem_wr_en  = r0_we;
    end else if (r1_gnt) begin
      mem_addr   = r1_addr;
      mem_dat_in = r1_wdata;
      mem_wr_en  = r1_we;
    end
  end

  // Next state, lock counter, round-robin history and read-data capture.
  always_comb begin
    state_d    = state_q;
    last_srv_d = last_srv_q;
    if (lock_timeout) begin
      state_d = IDLE;
    end else if (r0_gnt) begin
      last_srv_d = 1'b0;
      state_d    = r0_lock ? LOCK0 : IDLE;
    end else if (r1_gnt) begin
      last_srv_d = 1'b1;
      state_d    = r1_lock ? LOCK1 : IDLE;
    end

    // Count while staying in a lock; entry into a lock (or IDLE) restarts at zero.
    if (state_q != IDLE && state_d == state_q) lock_cnt_d = lock_cnt_q + 1'b1;
    else                                       lock_cnt_d = '0;

    r0_rvalid_d = r0_gnt && !r0_we;
    r1_rvalid_d = r1_gnt && !r1_we;
    r0_rdata_d  = r0_rvalid_d ? mem_dat_out : r0_rdata_q;
    r1_rdata_d  = r1_rvalid_d ? mem_dat_out : r1_rdata_q;
  end

  // State registers; reset abandons any lock without a timeout pulse.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_srv_q  <= 1'b1;
      lock_cnt_q  <= '0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_srv_q  <= last_srv_d;
      lock_cnt_q  <= lock_cnt_d;
      r0_rvalid_q <= r0_rvalid_d;
      r1_rvalid_q <= r1_rvalid_d;
      r0_rdata_q  <= r0_rdata_d;
      r1_rdata_q  <= r1_rdata_d;
    end
  end

  assign r0_rvalid = r0_rvalid_q;
  assign r1_rvalid = r1_rvalid_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. Cycle vectors hold the inputs and the expected grants and timeout.
// A 256-word memory model sits on the memory port. Expected read data is
// taken from a reference copy of the memory. It is queued when a read is
// granted and compared when rvalid appears.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LOCK_MAX = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, lock_timeout;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dat_in, mem_dat_out;
  logic          mem_wr_en;

  mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_lock(r0_lock), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_lock(r1_lock), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .lock_timeout(lock_timeout),
    .mem_addr(mem_addr), .mem_dat_in(mem_dat_in), .mem_wr_en(mem_wr_en),
    .mem_dat_out(mem_dat_out)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge.
  logic [DW-1:0] mem [256] = '{default: '0};
  assign mem_dat_out = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_dat_in;

  typedef struct {
    logic         r0_req, r0_we, r0_lock;
    logic [7:0]   r0_addr, r0_wdata;
    logic         r1_req, r1_we, r1_lock;
    logic [7:0]   r1_addr, r1_wdata;
    logic         g0, g1, to;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] ref_mem [256] = '{default: '0};
  logic [DW-1:0] q0[$], q1[$];
  logic [DW-1:0] last0 = '0, last1 = '0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got 0x%0h, wanted 0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input int q0a, w0, k0, a0, d0, q1a, w1, k1, a1, d1, g0, g1, to);
    vec_t v;
    v.r0_req = (q0a != 0); v.r0_we = (w0 != 0); v.r0_lock = (k0 != 0);
    v.r0_addr = a0[7:0];   v.r0_wdata = d0[7:0];
    v.r1_req = (q1a != 0); v.r1_we = (w1 != 0); v.r1_lock = (k1 != 0);
    v.r1_addr = a1[7:0];   v.r1_wdata = d1[7:0];
    v.g0 = (g0 != 0); v.g1 = (g1 != 0); v.to = (to != 0);
    return v;
  endfunction

  // Drive one cycle at posedge+1, check mid-cycle, then advance to the next posedge+1.
  task automatic apply_vec(input vec_t v, input int idx);
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din;
    r0_req = v.r0_req; r0_we = v.r0_we; r0_lock = v.r0_lock;
    r0_addr = v.r0_addr; r0_wdata = v.r0_wdata;
    r1_req = v.r1_req; r1_we = v.r1_we; r1_lock = v.r1_lock;
    r1_addr = v.r1_addr; r1_wdata = v.r1_wdata;
    #4;
    exp_wr = 1'b0; exp_addr = '0; exp_din = '0;
    if (v.g0) begin
      exp_wr = v.r0_we; exp_addr = v.r0_addr; exp_din = v.r0_wdata;
    end else if (v.g1) begin
      exp_wr = v.r1_we; exp_addr = v.r1_addr; exp_din = v.r1_wdata;
    end
    check("r0_gnt", idx, 32'(r0_gnt), 32'(v.g0));
    check("r1_gnt", idx, 32'(r1_gnt), 32'(v.g1));
    check("lock_timeout", idx, 32'(lock_timeout), 32'(v.to));
    check("mem_wr_en", idx, 32'(mem_wr_en), 32'(exp_wr));
    check("mem_addr", idx, 32'(mem_addr), 32'(exp_addr));
    check("mem_dat_in", idx, 32'(mem_dat_in), 32'(exp_din));
    // Reads granted last cycle must show up now.
    check("r0_rvalid", idx, 32'(r0_rvalid), 32'(q0.size() != 0));
    if (q0.size() != 0) last0 = q0.pop_front();
    check("r0_rdata", idx, 32'(r0_rdata), 32'(last0));
    check("r1_rvalid", idx, 32'(r1_rvalid), 32'(q1.size() != 0));
    if (q1.size() != 0) last1 = q1.pop_front();
    check("r1_rdata", idx, 32'(r1_rdata), 32'(last1));
    if (v.g0 && !v.r0_we) q0.push_back(ref_mem[v.r0_addr]);
    if (v.g1 && !v.r1_we) q1.push_back(ref_mem[v.r1_addr]);
    if (v.g0 && v.r0_we) ref_mem[v.r0_addr] = v.r0_wdata;
    if (v.g1 && v.r1_we) ref_mem[v.r1_addr] = v.r1_wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset with r0 attempting a write: nothing may reach the memory.
    r0_req = 1'b1; r0_we = 1'b1; r0_lock = 1'b0; r0_addr = 8'd5; r0_wdata = 8'hFF;
    r1_req = 1'b1; r1_we = 1'b0; r1_lock = 1'b0; r1_addr = 8'd6; r1_wdata = 8'h00;
    #3;
    check("rst r0_gnt", -1, 32'(r0_gnt), 32'd0);
    check("rst r1_gnt", -1, 32'(r1_gnt), 32'd0);
    check("rst mem_wr_en", -1, 32'(mem_wr_en), 32'd0);
    check("rst mem_addr", -1, 32'(mem_addr), 32'd0);
    check("rst mem_dat_in", -1, 32'(mem_dat_in), 32'd0);
    check("rst lock_timeout", -1, 32'(lock_timeout), 32'd0);
    check("rst r0_rvalid", -1, 32'(r0_rvalid), 32'd0);
    check("rst r1_rvalid", -1, 32'(r1_rvalid), 32'd0);
    check("rst r0_rdata", -1, 32'(r0_rdata), 32'd0);
    check("rst r1_rdata", -1, 32'(r1_rdata), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    //             r0: req we lk addr data   r1: req we lk addr data   g0 g1 to
    // Preload some words through both requesters.
    vecs.push_back(mk(1,1,0,  1,'h11,  0,0,0,  0,   0,  1,0,0));
    vecs.push_back(mk(1,1,0,  2,'h22,  0,0,0,  0,   0,  1,0,0));
    vecs.push_back(mk(1,1,0,  3,'h33,  0,0,0,  0,   0,  1,0,0));
    vecs.push_back(mk(0,0,0,  0,   0,  1,1,0, 20,'h44,  0,1,0));
    vecs.push_back(mk(0,0,0,  0,   0,  1,1,0, 30,'h55,  0,1,0));
    vecs.push_back(mk(1,1,0, 78,'h66,  0,0,0,  0,   0,  1,0,0));
    vecs.push_back(mk(0,0,0,  0,   0,  0,0,0,  0,   0,  0,0,0));
    // Write A5 to 60, read it back.
    vecs.push_back(mk(1,1,0, 60,'hA5,  0,0,0,  0,   0,  1,0,0));
    vecs.push_back(mk(1,0,0, 60,   0,  0,0,0,  0,   0,  1,0,0));
    vecs.push_back(mk(0,0,0,  0,   0,  0,0,0,  0,   0,  0,0,0));
    // r1 served last, then both contend: r0, r1, r0, r1.
    vecs.push_back(mk(0,0,0,  0,   0,  1,0,0, 10,   0,  0,1,0));
    vecs.push_back(mk(1,0,0, 20,   0,  1,0,0, 30,   0,  1,0,0));
    vecs.push_back(mk(1,0,0, 20,   0,  1,0,0, 30,   0,  0,1,0));
    vecs.push_back(mk(1,0,0, 20,   0,  1,0,0, 30,   0,  1,0,0));
    vecs.push_back(mk(1,0,0, 20,   0,  1,0,0, 30,   0,  0,1,0));
    // Back-to-back reads by r0; also the address 5 write blocked by reset.
    vecs.push_back(mk(1,0,0,  1,   0,  0,0,0,  0,   0,  1,0,0));
    vecs.push_back(mk(1,0,0,  2,   0,  0,0,0,  0,   0,  1,0,0));
    vecs.push_back(mk(1,0,0,  3,   0,  0,0,0,  0,   0,  1,0,0));
    vecs.push_back(mk(1,0,0,  5,   0,  0,0,0,  0,   0,  1,0,0));
    vecs.push_back(mk(0,0,0,  0,   0,  0,0,0,  0,   0,  0,0,0));
    // r0 writes 7F to 69, r1 reads it next cycle.
    vecs.push_back(mk(1,1,0, 69,'h7F,  0,0,0,  0,   0,  1,0,0));
    vecs.push_back(mk(0,0,0,  0,   0,  1,0,0, 69,   0,  0,1,0));
    vecs.push_back(mk(0,0,0,  0,   0,  0,0,0,  0,   0,  0,0,0));
    // Read-after-write by the same requester.
    vecs.push_back(mk(0,0,0,  0,   0,  1,1,0,100,'h5A,  0,1,0));
    vecs.push_back(mk(0,0,0,  0,   0,  1,0,0,100,   0,  0,1,0));
    // r0 served last; r1 then wins and locks for 3 cycles while r0 waits.
    vecs.push_back(mk(1,0,0,  2,   0,  0,0,0,  0,   0,  1,0,0));
    vecs.push_back(mk(1,0,0,  7,   0,  1,0,1,  5,   0,  0,1,0));
    vecs.push_back(mk(1,0,0,  7,   0,  1,0,1,  6,   0,  0,1,0));
    vecs.push_back(mk(1,0,0,  7,   0,  1,0,1,  8,   0,  0,1,0));
    vecs.push_back(mk(1,0,0,  7,   0,  1,0,0,  9,   0,  0,1,0));
    vecs.push_back(mk(1,0,0,  7,   0,  1,0,0,  9,   0,  1,0,0));
    vecs.push_back(mk(0,0,0,  0,   0,  1,0,0,  9,   0,  0,1,0));
    // r1 locks then goes quiet; one locked re-grant; forced release 15 cycles after entry.
    vecs.push_back(mk(0,0,0,  0,   0,  1,0,1, 11,   0,  0,1,0));
    for (int c = 0; c <= LOCK_MAX; c++) begin
      if (c == 5) vecs.push_back(mk(1,0,0, 12, 0,  1,0,1, 13, 0,  0,1,0));
      else        vecs.push_back(mk(1,0,0, 12, 0,  0,0,0,  0, 0,  0,0,(c == LOCK_MAX) ? 1 : 0));
    end
    vecs.push_back(mk(1,0,0, 12,   0,  0,0,0,  0,   0,  1,0,0));
    vecs.push_back(mk(0,0,0,  0,   0,  0,0,0,  0,   0,  0,0,0));
    // r0 lock holds r1 off, then releases.
    vecs.push_back(mk(1,1,1,200,'h33,  0,0,0,  0,   0,  1,0,0));
    vecs.push_back(mk(0,0,0,  0,   0,  1,0,0,200,   0,  0,0,0));
    vecs.push_back(mk(1,0,0,200,   0,  1,0,0,200,   0,  1,0,0));
    vecs.push_back(mk(0,0,0,  0,   0,  1,0,0,200,   0,  0,1,0));
    vecs.push_back(mk(0,0,0,  0,   0,  0,0,0,  0,   0,  0,0,0));
    // r0 writes EE to 77 and takes a lock, ahead of the reset sequence.
    vecs.push_back(mk(1,1,1, 77,'hEE,  0,0,0,  0,   0,  1,0,0));
    run_table();

    // Reset asserted in the middle of a granted write while locked.
    r0_req = 1'b1; r0_we = 1'b1; r0_lock = 1'b1; r0_addr = 8'd78; r0_wdata = 8'h99;
    r1_req = 1'b0; r1_we = 1'b0; r1_lock = 1'b0; r1_addr = 8'd0; r1_wdata = 8'h00;
    #4;
    check("pre-rst r0_gnt", -2, 32'(r0_gnt), 32'd1);
    check("pre-rst mem_wr_en", -2, 32'(mem_wr_en), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid-rst r0_gnt", -2, 32'(r0_gnt), 32'd0);
    check("mid-rst mem_wr_en", -2, 32'(mem_wr_en), 32'd0);
    check("mid-rst mem_addr", -2, 32'(mem_addr), 32'd0);
    check("mid-rst mem_dat_in", -2, 32'(mem_dat_in), 32'd0);
    check("mid-rst lock_timeout", -2, 32'(lock_timeout), 32'd0);
    q0.delete(); q1.delete();
    last0 = '0; last1 = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("in-rst mem_wr_en", c, 32'(mem_wr_en), 32'd0);
      check("in-rst lock_timeout", c, 32'(lock_timeout), 32'd0);
      check("in-rst r0_rvalid", c, 32'(r0_rvalid), 32'd0);
      check("in-rst r0_rdata", c, 32'(r0_rdata), 32'd0);
      check("in-rst r1_rdata", c, 32'(r1_rdata), 32'd0);
      check("mem[78] kept", c, 32'(mem[78]), 32'(ref_mem[78]));
    end
    r0_req = 1'b0; r0_we = 1'b0; r0_lock = 1'b0;
    rst_n = 1'b1;

    // After reset: lock abandoned, r0 favoured, written data intact.
    vecs.push_back(mk(1,0,0, 77,   0,  1,0,0, 78,   0,  1,0,0));
    vecs.push_back(mk(0,0,0,  0,   0,  1,0,0, 78,   0,  0,1,0));
    vecs.push_back(mk(0,0,0,  0,   0,  0,0,0,  0,   0,  0,0,0));
    vecs.push_back(mk(0,0,0,  0,   0,  0,0,0,  0,   0,  0,0,0));
    run_table();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
